// File: rtl/slice_assembler.sv
// slice_assembler: packs two-element beats into an N-element frame over an arbitrary
// (possibly negative, possibly ascending) packed index range, then holds it until consumed.
module slice_assembler #(
  parameter int MSB = 0,
  parameter int LSB = 0,
  parameter int EW = 2,
  localparam int N = (MSB > LSB ? MSB - LSB : LSB - MSB) + 1,
  localparam int LO = MSB < LSB ? MSB : LSB,
  localparam int PW = $clog2(N + 2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0][EW-1:0]        in_chunk,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MSB:LSB][EW-1:0]    out_data,
  output logic [PW-1:0]             fill_ptr
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam bit ASC = MSB < LSB;
  logic [0:0] state;
  logic [PW-1:0] off;
  logic take;
  logic last;
  assign in_ready = state == FILL && !flush;
  assign out_valid = state == HOLD;
  assign fill_ptr = state == HOLD ? PW'(N) : off;
  assign take = in_valid && in_ready;
  // this beat covers element HI (second element may fall past HI and is dropped)
  assign last = int'(off) + 2 >= N;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      off <= '0;
      out_data <= '0;
    end else if (flush || (state == HOLD && out_ready)) begin
      state <= FILL;
      off <= '0;
      out_data <= '0;
    end else if (take) begin
      for (int k = 0; k < N; k++) begin
        if (k == int'(off)) out_data[LO + k] <= in_chunk[ASC ? 1 : 0];
        if (k == int'(off) + 1) out_data[LO + k] <= in_chunk[ASC ? 0 : 1];
      end
      off <= off + PW'(2);
      if (last) state <= HOLD;
    end
  end
endmodule

// File: tb/tb_slice_assembler.sv
// tb_slice_assembler: six ranges side by side on shared stimulus, directed vectors plus
// random stalls checked against an element-level frame model.
module tb_slice_assembler;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [3:0] in_chunk = '0;
  logic ir[6], ov[6];
  logic [13:0] od[6];
  logic [3:0] fp[6];
  int checks = 0, errors = 0;
  int hold[6], off[6];
  int em[6][8];
  always #5 clk = ~clk;
  function automatic int msb_of(int g);
    return g == 0 ? 4 : g == 1 ? 6 : g == 2 ? 7 : g == 3 ? 0 : g == 4 ? 2 : 3;
  endfunction
  function automatic int lsb_of(int g);
    return g == 0 ? -2 : g == 1 ? 0 : g == 2 ? 2 : g == 3 ? 6 : g == 4 ? 7 : 3;
  endfunction
  function automatic int lo_of(int g);
    return msb_of(g) < lsb_of(g) ? msb_of(g) : lsb_of(g);
  endfunction
  function automatic int hi_of(int g);
    return msb_of(g) > lsb_of(g) ? msb_of(g) : lsb_of(g);
  endfunction
  for (genvar g = 0; g < 6; g++) begin : gi
    localparam int M = msb_of(g);
    localparam int L = lsb_of(g);
    localparam int NG = (M > L ? M - L : L - M) + 1;
    logic [NG*2-1:0] d;
    logic [$clog2(NG+2)-1:0] f;
    logic r, v;
    slice_assembler #(.MSB(M), .LSB(L), .EW(2)) u (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r),
      .in_chunk(in_chunk), .out_valid(v), .out_ready(out_ready), .out_data(d), .fill_ptr(f));
    assign ir[g] = r;
    assign ov[g] = v;
    assign od[g] = 14'(d);
    assign fp[g] = 4'(f);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic mclear(input int g);
    hold[g] = 0;
    off[g] = 0;
    for (int k = 0; k < 8; k++) em[g][k] = 0;
  endtask
  task automatic mstep();
    for (int g = 0; g < 6; g++) begin
      int p, hi;
      bit a;
      hi = hi_of(g);
      a = msb_of(g) < lsb_of(g);
      if (flush) mclear(g);
      else if (hold[g] != 0) begin
        if (out_ready) mclear(g);
      end else if (in_valid) begin
        p = lo_of(g) + off[g];
        em[g][off[g]] = a ? int'(in_chunk[3:2]) : int'(in_chunk[1:0]);
        if (p + 1 <= hi) em[g][off[g] + 1] = a ? int'(in_chunk[1:0]) : int'(in_chunk[3:2]);
        off[g] += 2;
        if (p + 1 >= hi) hold[g] = 1;
      end
    end
  endtask
  function automatic logic [13:0] exp_data(int g);
    logic [13:0] r = '0;
    for (int i = lo_of(g); i <= hi_of(g); i++) begin
      int pos = msb_of(g) >= lsb_of(g) ? i - lsb_of(g) : lsb_of(g) - i;
      r |= 14'(em[g][i - lo_of(g)]) << (2 * pos);
    end
    return r;
  endfunction
  task automatic check_all();
    for (int g = 0; g < 6; g++) begin
      int n = hi_of(g) - lo_of(g) + 1;
      chk($sformatf("rnd cfg%0d in_ready", g), 32'(ir[g]), 32'(hold[g] == 0 && !flush));
      chk($sformatf("rnd cfg%0d out_valid", g), 32'(ov[g]), 32'(hold[g] != 0));
      chk($sformatf("rnd cfg%0d out_data", g), 32'(od[g]), 32'(exp_data(g)));
      chk($sformatf("rnd cfg%0d fill_ptr", g), 32'(fp[g]), hold[g] != 0 ? 32'(n) : 32'(off[g]));
    end
  endtask
  task automatic check_zero(input string tag);
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("%s cfg%0d out_valid", tag, g), 32'(ov[g]), 0);
      chk($sformatf("%s cfg%0d out_data", tag, g), 32'(od[g]), 0);
      chk($sformatf("%s cfg%0d fill_ptr", tag, g), 32'(fp[g]), 0);
    end
  endtask
  task automatic beats(input int cnt, input logic [3:0] b0, input logic [3:0] b1,
                       input logic [3:0] b2, input logic [3:0] b3);
    logic [3:0] bs[4];
    bs = '{b0, b1, b2, b3};
    for (int b = 0; b < cnt; b++) begin
      in_valid = 1;
      in_chunk = bs[b];
      @(negedge clk);
    end
    in_valid = 0;
  endtask
  typedef struct {int cfg; logic [13:0] data; int fp;} vec_t;
  vec_t vt[6];
  initial begin
    vt = '{'{0, 14'h2BE4, 7}, '{1, 14'h2BE4, 7}, '{2, 14'h0BE4, 6},
           '{3, 14'h13AC, 7}, '{4, 14'h04EB, 6}, '{5, 14'h0000, 1}};
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1;
    #1 for (int g = 0; g < 6; g++) chk($sformatf("post-reset cfg%0d in_ready", g), 32'(ir[g]), 1);
    @(negedge clk);
    beats(3, 4'b0100, 4'b1110, 4'b1011, 4'b0000);
    chk("latency cfg0 out_valid after 3 beats", 32'(ov[0]), 0);
    chk("latency cfg2 out_valid after 3 beats", 32'(ov[2]), 1);
    beats(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    for (int t = 0; t < 6; t++) begin
      chk($sformatf("vec cfg%0d out_valid", vt[t].cfg), 32'(ov[vt[t].cfg]), 1);
      chk($sformatf("vec cfg%0d out_data", vt[t].cfg), 32'(od[vt[t].cfg]), 32'(vt[t].data));
      chk($sformatf("vec cfg%0d fill_ptr", vt[t].cfg), 32'(fp[vt[t].cfg]), 32'(vt[t].fp));
    end
    in_valid = 1;
    in_chunk = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold cfg0 in_ready", 32'(ir[0]), 0);
      chk("hold cfg0 out_data stable", 32'(od[0]), 32'h2BE4);
    end
    out_ready = 1;
    @(negedge clk);
    chk("consume cfg0 out_data", 32'(od[0]), 0);
    chk("consume cfg0 fill_ptr", 32'(fp[0]), 0);
    chk("consume cfg0 in_ready", 32'(ir[0]), 1);
    in_valid = 0;
    out_ready = 0;
    @(negedge clk);
    beats(2, 4'b1110, 4'b0111, 4'b0, 4'b0);
    flush = 1;
    in_valid = 1;
    in_chunk = 4'hF;
    @(negedge clk);
    chk("flush cfg2 fill_ptr", 32'(fp[2]), 0);
    chk("flush cfg2 out_data", 32'(od[2]), 0);
    chk("flush cfg2 in_ready", 32'(ir[2]), 0);
    flush = 0;
    beats(3, 4'b1001, 4'b0110, 4'b1111, 4'b0);
    chk("fresh cfg2 out_valid", 32'(ov[2]), 1);
    chk("fresh cfg2 out_data", 32'(od[2]), 32'h0F69);
    chk("fresh cfg2 fill_ptr", 32'(fp[2]), 6);
    flush = 1;
    @(negedge clk);
    flush = 0;
    beats(2, 4'b1011, 4'b1101, 4'b0, 4'b0);
    #2 rst_n = 0;
    #1 check_zero("async mid-frame");
    @(negedge clk);
    rst_n = 1;
    beats(4, 4'b0111, 4'b1101, 4'b0110, 4'b1011);
    chk("pre-reset cfg1 out_valid", 32'(ov[1]), 1);
    #2 rst_n = 0;
    #1 check_zero("async hold");
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    check_zero("no frame after reset");
    out_ready = 0;
    for (int g = 0; g < 6; g++) mclear(g);
    for (int c = 0; c < 2000; c++) begin
      check_all();
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 1) == 1;
      flush = $urandom_range(0, 99) < 3;
      in_chunk = 4'($urandom);
      mstep();
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
